// File: rtl/enc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : enc_pipe
// Purpose  : Parametrised, pipelined priority encoder. Returns the index of
//            the highest (MSB mode) or lowest (LSB mode) set bit of a
//            WIDTH-bit vector through a radix-8 reduction tree, with
//            valid/ready backpressure and bubble-collapsing stages.
// Revision : 1.0 - initial release
// ============================================================================
module enc_pipe #(
  parameter int WIDTH = 64,
  parameter int PIPE  = 1,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [IDX_W-1:0] out_data_o,
  output logic             out_zero_o,
  output logic             out_mode_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  // Tree geometry: input is zero-padded to 8^LEVELS bits.
  localparam int LOG2W   = $clog2(WIDTH);
  localparam int LEVELS  = (LOG2W + 2) / 3;
  localparam int PAD_W   = 1 << (3 * LEVELS);
  localparam int FULL_IW = 3 * LEVELS;
  localparam int S       = (PIPE != 0) ? LEVELS : 1;
  localparam int LAST    = LEVELS - 1;

  // Bit offset of level l's nonzero flags inside the flattened st_nz bus.
  function automatic int nz_off(input int l);
    int acc;
    acc = 0;
    for (int j = 0; j < l; j++) acc += 1 << (3 * (LEVELS - 1 - j));
    return acc;
  endfunction

  // Bit offset of level l's index fields inside the flattened st_idx bus.
  function automatic int idx_off(input int l);
    int acc;
    acc = 0;
    for (int j = 0; j < l; j++) acc += (1 << (3 * (LEVELS - 1 - j))) * 3 * (j + 1);
    return acc;
  endfunction

  localparam int NZ_TOT  = nz_off(LEVELS);
  localparam int IDX_TOT = idx_off(LEVELS);

  // Pick the highest (lsb=0) or lowest (lsb=1) nonzero child of a group of 8.
  // An empty group selects child 0, whose subtree index is itself all zeros.
  function automatic logic [2:0] pick(input logic [7:0] nz, input logic lsb);
    logic [2:0] sel;
    sel = 3'd0;
    if (lsb) begin
      for (int c = 7; c >= 0; c--) if (nz[c]) sel = 3'(c);
    end else begin
      for (int c = 0; c < 8; c++) if (nz[c]) sel = 3'(c);
    end
    return sel;
  endfunction

  // --------------------------------------------------------------------------
  // Stage handshake
  // --------------------------------------------------------------------------
  logic [S-1:0] v_q;
  logic [S-1:0] v_d;
  logic [S-1:0] en;
  logic [S-1:0] up_v;

  // Bubble-collapsing enables: a stage may advance if empty or if the one
  // downstream advances.
  always_comb begin
    en       = '0;
    en[S-1]  = !v_q[S-1] || out_ready_i;
    for (int k = S - 2; k >= 0; k--) en[k] = !v_q[k] || en[k+1];
  end

  // Valid presented to each stage from upstream.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid_i;
    for (int k = 1; k < S; k++) up_v[k] = v_q[k-1];
  end

  // Next-state valids: take upstream valid when enabled, otherwise hold.
  always_comb begin
    v_d = (en & up_v) | (~en & v_q);
  end

  // Stage valid registers; reset flushes all in-flight entries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) v_q <= '0;
    else          v_q <= v_d;
  end

  // --------------------------------------------------------------------------
  // Reduction tree
  // --------------------------------------------------------------------------
  logic [PAD_W-1:0]  padded;
  wire  [NZ_TOT-1:0] st_nz;
  wire  [IDX_TOT-1:0] st_idx;
  wire  [LEVELS-1:0] st_mode;

  // Zero-pad the input; padded bits never win selection since they are 0.
  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = in_data_i;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int  N_OUT     = 1 << (3 * (LEVELS - 1 - l));
    localparam int  N_IN      = N_OUT * 8;
    localparam int  IW_IN     = 3 * l;
    localparam int  IW_OUT    = IW_IN + 3;
    localparam int  NZ_O      = nz_off(l);
    localparam int  IDX_O     = idx_off(l);
    localparam bit  STAGE_REG = (PIPE != 0) && (l < LEVELS - 1);

    logic [N_IN-1:0]         src_nz;
    logic                    src_mode;
    logic [N_OUT-1:0]        res_nz;
    logic [N_OUT*IW_OUT-1:0] res_idx;
    logic [2:0]              sel;

    if (l == 0) begin : g_first
      assign src_nz   = padded;
      assign src_mode = in_mode_i;

      // Leaf level: groups are raw input bits; index is just the 3-bit pick.
      always_comb begin
        res_nz  = '0;
        res_idx = '0;
        sel     = '0;
        for (int g = 0; g < N_OUT; g++) begin
          sel                         = pick(src_nz[g*8 +: 8], src_mode);
          res_nz[g]                   = |src_nz[g*8 +: 8];
          res_idx[g*IW_OUT +: IW_OUT] = sel;
        end
      end
    end else begin : g_inner
      logic [N_IN*IW_IN-1:0] src_idx;

      assign src_nz   = st_nz[nz_off(l-1) +: N_IN];
      assign src_idx  = st_idx[idx_off(l-1) +: N_IN*IW_IN];
      assign src_mode = st_mode[l-1];

      // Upper level: prepend the chosen child number to that child's index.
      always_comb begin
        res_nz  = '0;
        res_idx = '0;
        sel     = '0;
        for (int g = 0; g < N_OUT; g++) begin
          sel                         = pick(src_nz[g*8 +: 8], src_mode);
          res_nz[g]                   = |src_nz[g*8 +: 8];
          res_idx[g*IW_OUT +: IW_OUT] = {sel, src_idx[(g*8 + int'(sel))*IW_IN +: IW_IN]};
        end
      end
    end

    if (STAGE_REG) begin : g_reg
      logic [N_OUT-1:0]        nz_q,   nz_d;
      logic [N_OUT*IW_OUT-1:0] idx_q,  idx_d;
      logic                    mode_q, mode_d;

      // Payload loads only for a valid entry advancing into this stage.
      always_comb begin
        nz_d   = nz_q;
        idx_d  = idx_q;
        mode_d = mode_q;
        if (en[l] && up_v[l]) begin
          nz_d   = res_nz;
          idx_d  = res_idx;
          mode_d = src_mode;
        end
      end

      // Inter-level pipeline register.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          nz_q   <= '0;
          idx_q  <= '0;
          mode_q <= 1'b0;
        end else begin
          nz_q   <= nz_d;
          idx_q  <= idx_d;
          mode_q <= mode_d;
        end
      end

      assign st_nz[NZ_O +: N_OUT]            = nz_q;
      assign st_idx[IDX_O +: N_OUT*IW_OUT]   = idx_q;
      assign st_mode[l]                      = mode_q;
    end else begin : g_comb
      assign st_nz[NZ_O +: N_OUT]            = res_nz;
      assign st_idx[IDX_O +: N_OUT*IW_OUT]   = res_idx;
      assign st_mode[l]                      = src_mode;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic               last_nz;
  logic [FULL_IW-1:0] last_idx;
  logic [IDX_W-1:0]   out_data_q, out_data_d;
  logic               out_zero_q, out_zero_d;
  logic               out_mode_q, out_mode_d;

  assign last_nz  = st_nz[NZ_TOT-1];
  assign last_idx = st_idx[IDX_TOT-1 -: FULL_IW];

  // Padding makes the tree index wider than IDX_W; those bits are always 0.
  if (FULL_IW > IDX_W) begin : g_trunc
    wire unused_idx_hi = ^last_idx[FULL_IW-1:IDX_W];
  end

  // Final result: truncated index, forced to 0 for an all-zero vector.
  always_comb begin
    out_data_d = out_data_q;
    out_zero_d = out_zero_q;
    out_mode_d = out_mode_q;
    if (en[S-1] && up_v[S-1]) begin
      out_data_d = last_nz ? last_idx[IDX_W-1:0] : '0;
      out_zero_d = !last_nz;
      out_mode_d = st_mode[LAST];
    end
  end

  // Output payload register; holds while stalled and after valid drops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_data_q <= '0;
      out_zero_q <= 1'b0;
      out_mode_q <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_zero_q <= out_zero_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign in_ready_o  = en[0];
  assign out_valid_o = v_q[S-1];
  assign out_data_o  = out_data_q;
  assign out_zero_o  = out_zero_q;
  assign out_mode_o  = out_mode_q;

endmodule
`default_nettype wire

// File: doc/enc_pipe.md
Name: enc_pipe

Overview:
- Parametrised, pipelined priority encoder; the successor to the fixed 64-bit encoder.
- Returns the index of the highest set bit (MSB mode) or the lowest set bit (LSB mode) of a WIDTH-bit vector, selected per transaction.
- Uses a radix-8 reduction tree, optionally registered after every level, with valid/ready backpressure.
- Sits between bitmap producers (arbiters, free-lists, leading-zero logic) and index consumers that may stall.

Parameters:
- WIDTH, 64: input vector width. Power of 2, 2..4096. Internally zero-padded to 8^LEVELS bits, where LEVELS = ceil(log2(WIDTH)/3).
- PIPE, 1: 1 = register after every tree level, latency LEVELS. 0 = combinational tree plus one output register, latency 1.
- IDX_W, $clog2(WIDTH): output index width. Derived; not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- in_data_i  in  WIDTH  vector to encode.
- in_mode_i  in  1  0 = MSB-first, 1 = LSB-first.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- out_data_o  out  IDX_W  encoded bit index.
- out_zero_o  out  1  input vector was all zeros.
- out_mode_o  out  1  mode of this result.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  output ready.

Behaviour:
- Decided: one clock (clk_i); reset rst_n_i is asynchronous, active-low. On reset all stage valids clear and out_data_o, out_zero_o, out_mode_o, out_valid_o = 0. Asserting reset mid-operation discards all in-flight transactions immediately.
- Transfer rules:
  - An input transfer occurs when in_valid_i && in_ready_o.
  - An output transfer occurs when out_valid_o && out_ready_i.
- Pipeline: S = PIPE ? LEVELS : 1 stages, each holding a valid bit v[k] and its payload.
- Enables (bubble-collapsing):
  - en[S-1] = !v[S-1] || out_ready_i.
  - en[k] = !v[k] || en[k+1].
  - in_ready_o = en[0]. This path is combinational from out_ready_i, which is allowed.
- Stage update when en[k] = 1:
  - v[k] takes the upstream valid.
  - Payload loads only if the upstream valid is 1; otherwise the payload holds.
  - When en[k] = 0, the stage holds completely.
- Output stability: out_data_o, out_zero_o and out_mode_o are stable while out_valid_o && !out_ready_i. They keep their last value after out_valid_o drops.
- Level function: each level takes groups of 8 (index, nonzero) pairs from the level below. It picks the highest nonzero group (MSB mode) or the lowest (LSB mode), appends 3 index bits and ORs the nonzero flags. Level 0 groups are raw input bits.
- Padding: padded bits are 0 and can never be selected. The result is truncated to IDX_W bits.
- Zero input: out_zero_o = 1 and out_data_o = 0 in both modes.
- Single-bit input: both modes return the same index.
- Throughput: one result per cycle when out_ready_i is held high. Latency is exactly S cycles from input transfer to out_valid_o.
- Simultaneous events: input and output transfers in the same cycle with a full pipeline are allowed with no bubble. Results stay in input order.
- Mode: mode travels with its data. Mixed-mode back-to-back inputs are legal.
- Stall state: a stalled pipeline holding S entries has in_ready_o = 0. Entries are never dropped or duplicated.

Test Plan:
- WIDTH=64, PIPE=1 (S=2), out_ready_i = 1:
  - in_data_i = 0x0000_0100_0000_0010, mode 0 → out_data_o = 40, out_zero_o = 0, valid 2 cycles after input.
  - Same data, mode 1 → out_data_o = 4.
- WIDTH=64, in_data_i = 0, both modes → out_zero_o = 1, out_data_o = 0, out_mode_o echoes the input mode.
- WIDTH=64, PIPE=1, back-to-back inputs 0x1, 0x8000_0000_0000_0000, 0xFF00 (mode 0,0,1), with out_ready_i low for 3 cycles after the first result:
  - Outputs are 0, 63, 8 in order.
  - in_ready_o drops only once both stages are full.
  - out_data_o holds 0 throughout the stall.
  - No loss or duplication.
- WIDTH=512 (LEVELS=3), PIPE=1, single bit 511 then bit 0, each in both modes → 511 and 0 respectively; latency 3 cycles.
- WIDTH=32 (padded to 64), PIPE=0:
  - 0x8000_0001 mode 0 → 31; mode 1 → 0.
  - Latency 1 cycle.
- Reset asserted asynchronously mid-cycle with 2 entries in flight → out_valid_o falls without waiting for a clock edge. After release, the first new input produces the correct result with no stale outputs.
